// File: rtl/decoder2to4_seq.sv
// Sequenced 2-to-4 decoder: an accepted code drives one registered line for
// PULSE_LEN cycles, then a one-cycle gap, before the next code is taken.
//
//  state | meaning
//  IDLE  | ready; accepts a code when in_valid is high
//  DRIVE | selected line held high while the down-counter runs out
//  GAP   | all lines low for one cycle before returning to IDLE
module decoder2to4_seq #(
    parameter int PULSE_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       y1,
    input  logic       y0,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       w3,
    output logic       w2,
    output logic       w1,
    output logic       w0,
    output logic       busy,
    output logic [7:0] acc_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] LOAD = 4'(PULSE_LEN - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] code_q, code_d;
    logic [3:0] w_q, w_d;
    logic [7:0] acc_q, acc_d;
    logic       accept;

    function automatic logic [3:0] onehot(input logic [1:0] code);
        logic [3:0] r;
        r = 4'b0000;
        case (code)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            default: r = 4'b1000;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = DRIVE;
            DRIVE:   if (cnt_q == 4'd0) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
    end

    assign accept = in_valid && in_ready;

    // The line register is loaded from the live inputs only on the accepting
    // edge; afterwards the captured code alone keeps it asserted.
    always_comb begin
        cnt_d  = cnt_q;
        code_d = code_q;
        w_d    = 4'b0000;
        acc_d  = acc_q;
        if (accept) begin
            cnt_d  = LOAD;
            code_d = {y1, y0};
            w_d    = onehot({y1, y0});
            if (acc_q != 8'hFF) acc_d = acc_q + 8'd1;
        end else if (state_q == DRIVE && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            w_d   = onehot(code_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            code_q <= 2'd0;
            w_q    <= 4'b0000;
            acc_q  <= 8'd0;
        end else begin
            cnt_q  <= cnt_d;
            code_q <= code_d;
            w_q    <= w_d;
            acc_q  <= acc_d;
        end
    end

    assign {w3, w2, w1, w0} = w_q;
    assign acc_cnt          = acc_q;

endmodule

// File: tb/tb_decoder2to4_seq.sv
// Directed bench for decoder2to4_seq: a PULSE_LEN=4 instance for the main
// scenarios and a PULSE_LEN=1 instance for the minimum-pulse cadence.
module tb_decoder2to4_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       y1, y0, in_valid;
    logic       in_ready, w3, w2, w1, w0, busy;
    logic [7:0] acc_cnt;

    logic       yb1, yb0, vb;
    logic       rb, b3, b2, b1, b0, busy_b;
    logic [7:0] acc_b;

    int checks = 0;
    int errors = 0;
    int exp_acc = 0;

    always #5 clk = ~clk;

    decoder2to4_seq #(.PULSE_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .y1(y1), .y0(y0), .in_valid(in_valid),
        .in_ready(in_ready), .w3(w3), .w2(w2), .w1(w1), .w0(w0),
        .busy(busy), .acc_cnt(acc_cnt)
    );

    decoder2to4_seq #(.PULSE_LEN(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .y1(yb1), .y0(yb0), .in_valid(vb),
        .in_ready(rb), .w3(b3), .w2(b2), .w1(b1), .w0(b0),
        .busy(busy_b), .acc_cnt(acc_b)
    );

    typedef struct {
        logic [1:0] code;
        logic [3:0] exp_w;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready", int'(in_ready), 1);
    endtask

    // Current time is just after the accepting edge (cycle 1).
    task automatic check_pulse(input string name, input logic [3:0] exp_w);
        for (int k = 1; k <= 4; k++) begin
            check({name, "_w"}, int'({w3, w2, w1, w0}), int'(exp_w));
            check({name, "_busy"}, int'(busy), 1);
            check({name, "_rdy"}, int'(in_ready), 0);
            tick();
        end
        check({name, "_gap_w"}, int'({w3, w2, w1, w0}), 0);
        check({name, "_gap_rdy"}, int'(in_ready), 0);
        tick();
        check({name, "_idle_rdy"}, int'(in_ready), 1);
        check({name, "_idle_busy"}, int'(busy), 0);
        check({name, "_acc"}, int'(acc_cnt), exp_acc);
    endtask

    task automatic accept_code(input logic [1:0] code);
        {y1, y0} = code;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_acc  = (exp_acc < 255) ? exp_acc + 1 : 255;
    endtask

    initial begin
        vecs[0] = '{2'd0, 4'b0001};
        vecs[1] = '{2'd1, 4'b0010};
        vecs[2] = '{2'd2, 4'b0100};
        vecs[3] = '{2'd3, 4'b1000};

        rst_n = 1'b0; y1 = 1'b0; y0 = 1'b0; in_valid = 1'b0;
        yb1 = 1'b1; yb0 = 1'b1; vb = 1'b0;
        #12;
        check("rst_w", int'({w3, w2, w1, w0}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rdy", int'(in_ready), 1);
        check("rst_acc", int'(acc_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single decode of code 2
        accept_code(2'd2);
        check_pulse("single", 4'b0100);

        // All codes from the vector table
        foreach (vecs[i]) begin
            wait_ready();
            accept_code(vecs[i].code);
            check_pulse("table", vecs[i].exp_w);
        end

        // Ignore inputs while busy; second code waits for in_ready
        wait_ready();
        {y1, y0} = 2'd1;
        in_valid = 1'b1;
        tick();
        exp_acc++;
        {y1, y0} = 2'd3;
        for (int k = 1; k <= 4; k++) begin
            check("busy_w1", int'({w3, w2, w1, w0}), 4'b0010);
            check("busy_acc", int'(acc_cnt), exp_acc);
            tick();
        end
        check("busy_gap_w", int'({w3, w2, w1, w0}), 0);
        tick();
        check("busy_ready6", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        exp_acc++;
        check("busy_second_w3", int'({w3, w2, w1, w0}), 4'b1000);
        check("busy_second_acc", int'(acc_cnt), exp_acc);
        tick();
        wait_ready();

        // Minimum pulse on the PULSE_LEN=1 instance, continuous valid
        check("min_rdy0", int'(rb), 1);
        vb = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("min_w3", int'({b3, b2, b1, b0}), (k % 3 == 1) ? 8 : 0);
            check("min_rdy", int'(rb), (k % 3 == 0) ? 1 : 0);
        end
        vb = 1'b0;
        tick();
        tick();

        // Async reset in the middle of a w3 pulse
        wait_ready();
        accept_code(2'd3);
        tick();
        check("ar_pre_w3", int'({w3, w2, w1, w0}), 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_w", int'({w3, w2, w1, w0}), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_acc", int'(acc_cnt), 0);
        check("ar_rdy", int'(in_ready), 1);
        exp_acc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        accept_code(2'd0);
        check_pulse("ar_post", 4'b0001);

        // Saturation from a clean reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_acc = 0;
        for (int i = 1; i <= 256; i++) begin
            wait_ready();
            accept_code(2'd0);
            if (i == 254) check("sat_254", int'(acc_cnt), 254);
            if (i == 255) check("sat_255", int'(acc_cnt), 255);
            if (i == 256) check("sat_256", int'(acc_cnt), 255);
        end
        wait_ready();
        check("sat_hold", int'(acc_cnt), exp_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder2to4_seq.md
DECODER2TO4_SEQ -- requirements
Module: decoder2to4_seq

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 4, which sets the number of cycles a decoded line is held high (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port y1, input, 1, code MSB.
REQ-005 SHALL have port y0, input, 1, code LSB.
REQ-006 SHALL have port in_valid, input, 1, which indicates that the code on y1/y0 is offered.
REQ-007 SHALL have port in_ready, output, 1, which indicates that the block accepts a code this cycle.
REQ-008 SHALL have ports w3, w2, w1, w0, output, 1 each, the registered one-hot decoded lines.
REQ-009 SHALL have port busy, output, 1, which is high whenever the FSM is not in IDLE.
REQ-010 SHALL have port acc_cnt, output, 8, the saturating count of accepted codes.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, DRIVE, GAP.
REQ-012 SHALL drive in_ready = 1 only in IDLE; in_ready SHALL be a function of state only, never of in_valid.
REQ-013 SHALL accept a code on a rising edge where in_valid && in_ready, capture {y1,y0}, and move IDLE->DRIVE.
REQ-014 SHALL drive, in DRIVE, exactly one of w3..w0 high: code 0->w0, 1->w1, 2->w2, 3->w3; the line rises on the first cycle after the accepting edge (latency 1).
REQ-015 SHALL hold the selected line high for exactly PULSE_LEN consecutive cycles, using a 4-bit down-counter loaded with PULSE_LEN-1 on acceptance; DRIVE->GAP when the counter is 0.
REQ-016 SHALL force all w lines low in GAP for exactly one cycle, then go GAP->IDLE.
REQ-017 SHALL keep all w lines low in IDLE and GAP; all w outputs SHALL come directly from registers (no glitches from y1/y0).
REQ-018 SHALL ignore y1/y0 changes after acceptance; the captured code alone determines the output.
REQ-019 SHALL ignore in_valid while busy; there is no queueing and no error flag. The source must hold in_valid until it sees in_ready.
REQ-020 SHALL produce back-to-back accepted codes at most one per PULSE_LEN+2 cycles (PULSE_LEN drive + 1 gap + 1 idle-accept).
REQ-021 SHALL increment acc_cnt by 1 on each acceptance and saturate at 255 (no wrap).
REQ-022 SHALL drive busy = 1 in DRIVE and GAP.

Reset
REQ-023 SHALL force, while rst_n = 0, regardless of clk: state = IDLE, w3..w0 = 0, busy = 0, in_ready = 1 (state-derived), acc_cnt = 0, down-counter = 0.
REQ-024 SHALL, on a reset asserted mid-DRIVE, drop the active line immediately (asynchronously) and discard the captured code; no GAP cycle follows.
REQ-025 SHALL make the first acceptance possible on the first rising edge after rst_n deasserts.

Verification
REQ-026 SHALL cover single decode: PULSE_LEN=4, reset, then y1y0=10 with in_valid for 1 cycle -> w2 high for cycles 1..4 after acceptance, all w low at cycle 5, in_ready high at cycle 6, acc_cnt=1.
REQ-027 SHALL cover all codes: apply 00, 01, 10, 11 sequentially, each held until accepted -> w0, w1, w2, w3 pulse in order, each 4 cycles, never two lines high together, acc_cnt=4.
REQ-028 SHALL cover ignore-while-busy: accept 01, then change y1y0 to 11 with in_valid held high during DRIVE -> w1 completes its full 4-cycle pulse, and 11 is accepted only when in_ready returns (6 cycles after the first accept).
REQ-029 SHALL cover async reset: assert rst_n=0 mid-way between clk edges during the w3 pulse -> w3 falls with no clock edge, busy=0, acc_cnt=0; after release, code 00 accepted on the first edge -> w0 pulses.
REQ-030 SHALL cover saturation: 256 accepted codes -> acc_cnt reads 255 after the 255th and stays at 255 after the 256th.
REQ-031 SHALL cover minimum pulse: PULSE_LEN=1, continuous in_valid with code 11 -> w3 high for 1 cycle in every 3, and in_ready high exactly on the acceptance cycles.
